// File: rtl/mips_cpu_lsu.sv
// Load/store unit bridging the multicycle core to an Avalon-MM master port.
// One request in flight: lane steering on the way out, extraction and extension on the way back.
module mips_cpu_lsu #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_error,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    input  logic                waitrequest,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   readdata
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BYTES-1:0]   be_q, be_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               write_q, write_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               error_q, error_d;

    // Request decode: legality, lane enables and lane-shifted store data.
    int                 req_n;
    int                 req_off;
    logic               req_legal;
    logic [BYTES-1:0]   req_be;
    logic [DATA_W-1:0]  req_mask;
    logic [DATA_W-1:0]  req_lanes;

    always_comb begin
        req_n     = 1 << req_size;
        req_off   = int'(req_addr[OFF_W-1:0]);
        req_legal = (req_n <= BYTES) && ((req_off & (req_n - 1)) == 0);
        req_be    = '0;
        req_mask  = '0;
        for (int k = 0; k < BYTES; k++) begin
            req_be[k]         = (k >= req_off) && (k < req_off + req_n);
            req_mask[8*k +: 8] = (k < req_n) ? 8'hFF : 8'h00;
        end
        req_lanes = (req_wdata & req_mask) << (8 * req_off);
    end

    // Load return path: shift the addressed bytes down, then extend above size.
    int                 ld_n;
    logic [DATA_W-1:0]  ld_shifted;
    logic               ld_sign;
    logic [DATA_W-1:0]  ld_data;

    always_comb begin
        ld_n       = 1 << size_q;
        ld_shifted = readdata >> (8 * int'(off_q));
        ld_sign    = 1'b0;
        for (int k = 0; k < BYTES; k++) begin
            if (k == ld_n - 1) begin
                ld_sign = ld_shifted[8*k + 7];
            end
        end
        ld_data = '0;
        for (int k = 0; k < BYTES; k++) begin
            ld_data[8*k +: 8] = (k < ld_n) ? ld_shifted[8*k +: 8]
                                           : {8{signed_q & ld_sign}};
        end
    end

    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        error_d  = error_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rdata_d = '0;
                    if (req_legal) begin
                        state_d  = REQ;
                        addr_d   = req_addr & ~ADDR_W'(BYTES - 1);
                        be_d     = req_be;
                        wdata_d  = req_lanes;
                        write_d  = req_write;
                        size_d   = req_size;
                        signed_d = req_signed;
                        off_d    = req_addr[OFF_W-1:0];
                        cnt_d    = '0;
                        error_d  = 1'b0;
                    end else begin
                        state_d = DONE;
                        error_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (!waitrequest) begin
                    state_d = write_q ? DONE : RDATA;
                end else if (MAX_WAIT != 0) begin
                    cnt_d = cnt_inc;
                    // Abort once the stall count hits the limit with the bus still stalling.
                    if (cnt_inc == CNT_W'(MAX_WAIT)) begin
                        state_d = DONE;
                        error_d = 1'b1;
                    end
                end
            end
            RDATA: begin
                rdata_d = ld_data;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                error_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            off_q    <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_error = error_q;
    assign resp_rdata = rdata_q;
    assign read       = (state_q == REQ) && !write_q;
    assign write      = (state_q == REQ) && write_q;
    assign address    = addr_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Directed bench for mips_cpu_lsu: a 32-bit instance with unbounded waits and
// a 64-bit instance with MAX_WAIT=4, selected per transaction.
module tb_mips_cpu_lsu;

    logic        clk;
    logic        reset;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] rdata;
    logic        waitreq;
    logic        a_valid, b_valid;
    logic        sel;

    logic        a_ready, a_rv, a_err, a_read, a_write;
    logic [31:0] a_rdata, a_addr, a_wd;
    logic [3:0]  a_be;
    logic        b_ready, b_rv, b_err, b_read, b_write;
    logic [63:0] b_rdata, b_wd;
    logic [31:0] b_addr;
    logic [7:0]  b_be;

    logic        m_ready, m_rv, m_err, m_read, m_write;
    logic [63:0] m_rdata, m_wd;
    logic [31:0] m_addr;
    logic [7:0]  m_be;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic        o_rd, o_wr, o_stable, o_both, o_err, o_ready_done, o_after_rv, o_after_ready;
    logic [31:0] o_addr;
    logic [7:0]  o_be;
    logic [63:0] o_wd, o_rdata;
    int          o_rw, o_lat;

    mips_cpu_lsu #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(0)) u_dut32 (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]),
        .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_error(a_err),
        .address(a_addr), .read(a_read), .write(a_write), .waitrequest(waitreq),
        .writedata(a_wd), .byteenable(a_be), .readdata(rdata[31:0])
    );

    mips_cpu_lsu #(.DATA_W(64), .ADDR_W(32), .MAX_WAIT(4)) u_dut64 (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_error(b_err),
        .address(b_addr), .read(b_read), .write(b_write), .waitrequest(waitreq),
        .writedata(b_wd), .byteenable(b_be), .readdata(rdata)
    );

    assign m_ready = sel ? b_ready : a_ready;
    assign m_rv    = sel ? b_rv    : a_rv;
    assign m_err   = sel ? b_err   : a_err;
    assign m_read  = sel ? b_read  : a_read;
    assign m_write = sel ? b_write : a_write;
    assign m_rdata = sel ? b_rdata : {32'h0, a_rdata};
    assign m_wd    = sel ? b_wd    : {32'h0, a_wd};
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_be    = sel ? b_be    : {4'h0, a_be};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Issues one request and records what the selected DUT does with it.
    // nwait = number of leading bus cycles that see waitrequest=1.
    task automatic xact(input logic sel_b, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input int nwait);
        sel = sel_b;
        @(negedge clk);
        req_write = w; req_size = sz; req_signed = sg; req_addr = addr;
        req_wdata = wd; rdata = rd; waitreq = 1'b0;
        if (sel_b) b_valid = 1'b1; else a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        o_rd = m_read; o_wr = m_write; o_addr = m_addr; o_be = m_be; o_wd = m_wd;
        o_rw = 0; o_stable = 1'b1; o_both = 1'b0; o_lat = -1; o_err = 1'b0;
        o_rdata = '0; o_ready_done = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (m_read && m_write) o_both = 1'b1;
            if (m_read || m_write) begin
                o_rw++;
                if (m_addr !== o_addr || m_be !== o_be || m_wd !== o_wd) o_stable = 1'b0;
            end
            waitreq = (m_read || m_write) && (o_rw <= nwait);
            if (m_rv) begin
                o_lat = c; o_err = m_err; o_rdata = m_rdata; o_ready_done = m_ready;
                break;
            end
            @(negedge clk);
        end
        waitreq = 1'b0;
        @(negedge clk);
        o_after_rv = m_rv; o_after_ready = m_ready;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (a_read !== 1'b0 || a_write !== 1'b0) $display("FAIL reset_rw got %b%b want 00", a_read, a_write); else pass_cnt++;
        total_cnt++; if (a_rv !== 1'b0 || a_err !== 1'b0) $display("FAIL reset_resp got %b%b want 00", a_rv, a_err); else pass_cnt++;
        total_cnt++; if (a_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", a_rdata); else pass_cnt++;
        total_cnt++; if (a_addr !== 32'h0 || a_wd !== 32'h0 || a_be !== 4'h0) $display("FAIL reset_bus got %h/%h/%h want 0/0/0", a_addr, a_wd, a_be); else pass_cnt++;
        total_cnt++; if (b_read !== 1'b0 || b_rv !== 1'b0 || b_be !== 8'h0) $display("FAIL reset_b got %b/%b/%h want 0/0/00", b_read, b_rv, b_be); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (a_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", a_ready); else pass_cnt++;
    endtask

    task automatic test_store();
        xact(1'b0, 1'b1, 2'd2, 1'b0, 32'h1000, 64'hDEADBEEF, 64'h0, 0);
        total_cnt++; if (o_wr !== 1'b1 || o_rd !== 1'b0) $display("FAIL sw_rw got %b%b want 10", o_wr, o_rd); else pass_cnt++;
        total_cnt++; if (o_addr !== 32'h1000) $display("FAIL sw_addr got %h want 00001000", o_addr); else pass_cnt++;
        total_cnt++; if (o_be !== 8'h0F) $display("FAIL sw_be got %h want 0f", o_be); else pass_cnt++;
        total_cnt++; if (o_wd !== 64'hDEADBEEF) $display("FAIL sw_wd got %h want deadbeef", o_wd); else pass_cnt++;
        total_cnt++; if (o_lat !== 2) $display("FAIL sw_lat got %0d want 2", o_lat); else pass_cnt++;
        total_cnt++; if (o_err !== 1'b0 || o_rdata !== 64'h0) $display("FAIL sw_resp got %b/%h want 0/0", o_err, o_rdata); else pass_cnt++;
        total_cnt++; if (o_ready_done !== 1'b0) $display("FAIL sw_ready_done got %b want 0", o_ready_done); else pass_cnt++;
        total_cnt++; if (o_after_rv !== 1'b0 || o_after_ready !== 1'b1) $display("FAIL sw_pulse got %b/%b want 0/1", o_after_rv, o_after_ready); else pass_cnt++;

        xact(1'b0, 1'b1, 2'd0, 1'b0, 32'h1003, 64'h777777A5, 64'h0, 0);
        total_cnt++; if (o_addr !== 32'h1000 || o_be !== 8'h08) $display("FAIL sb_addr_be got %h/%h want 00001000/08", o_addr, o_be); else pass_cnt++;
        total_cnt++; if (o_wd !== 64'hA5000000) $display("FAIL sb_wd got %h want a5000000", o_wd); else pass_cnt++;
        total_cnt++; if (o_lat !== 2) $display("FAIL sb_lat got %0d want 2", o_lat); else pass_cnt++;

        xact(1'b0, 1'b1, 2'd1, 1'b0, 32'h1002, 64'hABCD1234, 64'h0, 0);
        total_cnt++; if (o_be !== 8'h0C) $display("FAIL sh_be got %h want 0c", o_be); else pass_cnt++;
        total_cnt++; if (o_wd !== 64'h12340000) $display("FAIL sh_wd got %h want 12340000", o_wd); else pass_cnt++;

        xact(1'b1, 1'b1, 2'd0, 1'b0, 32'h0D, 64'h5A, 64'h0, 0);
        total_cnt++; if (o_addr !== 32'h08 || o_be !== 8'h20) $display("FAIL sb64_addr_be got %h/%h want 00000008/20", o_addr, o_be); else pass_cnt++;
        total_cnt++; if (o_wd !== 64'h00005A0000000000) $display("FAIL sb64_wd got %h want 00005a0000000000", o_wd); else pass_cnt++;

        xact(1'b1, 1'b1, 2'd3, 1'b0, 32'h10, 64'h0123456789ABCDEF, 64'h0, 0);
        total_cnt++; if (o_be !== 8'hFF || o_wd !== 64'h0123456789ABCDEF) $display("FAIL sd64 got %h/%h want ff/0123456789abcdef", o_be, o_wd); else pass_cnt++;
        total_cnt++; if (o_lat !== 2 || o_err !== 1'b0) $display("FAIL sd64_resp got %0d/%b want 2/0", o_lat, o_err); else pass_cnt++;
    endtask

    task automatic test_load();
        xact(1'b0, 1'b0, 2'd1, 1'b1, 32'h2002, 64'h0, 64'h80011234, 0);
        total_cnt++; if (o_rd !== 1'b1 || o_wr !== 1'b0) $display("FAIL lh_rw got %b%b want 10", o_rd, o_wr); else pass_cnt++;
        total_cnt++; if (o_addr !== 32'h2000 || o_be !== 8'h0C) $display("FAIL lh_addr_be got %h/%h want 00002000/0c", o_addr, o_be); else pass_cnt++;
        total_cnt++; if (o_lat !== 3) $display("FAIL lh_lat got %0d want 3", o_lat); else pass_cnt++;
        total_cnt++; if (o_rdata !== 64'hFFFF8001 || o_err !== 1'b0) $display("FAIL lh_data got %h/%b want ffff8001/0", o_rdata, o_err); else pass_cnt++;

        xact(1'b0, 1'b0, 2'd1, 1'b0, 32'h2002, 64'h0, 64'h80011234, 0);
        total_cnt++; if (o_rdata !== 64'h00008001) $display("FAIL lhu_data got %h want 00008001", o_rdata); else pass_cnt++;
        total_cnt++; if (o_lat !== 3) $display("FAIL lhu_lat got %0d want 3", o_lat); else pass_cnt++;

        xact(1'b0, 1'b0, 2'd0, 1'b1, 32'h2000, 64'h0, 64'h80011234, 0);
        total_cnt++; if (o_rdata !== 64'h00000034 || o_be !== 8'h01) $display("FAIL lb0_data got %h/%h want 00000034/01", o_rdata, o_be); else pass_cnt++;

        xact(1'b0, 1'b0, 2'd0, 1'b1, 32'h2001, 64'h0, 64'h00008000, 0);
        total_cnt++; if (o_rdata !== 64'hFFFFFF80 || o_be !== 8'h02) $display("FAIL lb1_data got %h/%h want ffffff80/02", o_rdata, o_be); else pass_cnt++;
        total_cnt++; if (o_lat !== 3) $display("FAIL lb1_lat got %0d want 3", o_lat); else pass_cnt++;

        xact(1'b1, 1'b0, 2'd3, 1'b1, 32'h08, 64'h0, 64'hF0E1D2C3B4A59687, 0);
        total_cnt++; if (o_be !== 8'hFF || o_addr !== 32'h08) $display("FAIL ld64_be got %h/%h want ff/00000008", o_be, o_addr); else pass_cnt++;
        total_cnt++; if (o_rdata !== 64'hF0E1D2C3B4A59687 || o_lat !== 3) $display("FAIL ld64_data got %h/%0d want f0e1d2c3b4a59687/3", o_rdata, o_lat); else pass_cnt++;

        xact(1'b1, 1'b0, 2'd2, 1'b1, 32'h0C, 64'h0, 64'hF0E1D2C3B4A59687, 0);
        total_cnt++; if (o_be !== 8'hF0) $display("FAIL lw64_be got %h want f0", o_be); else pass_cnt++;
        total_cnt++; if (o_rdata !== 64'hFFFFFFFFF0E1D2C3) $display("FAIL lw64_data got %h want fffffffff0e1d2c3", o_rdata); else pass_cnt++;
    endtask

    task automatic test_wait();
        xact(1'b0, 1'b0, 2'd2, 1'b1, 32'h2000, 64'h0, 64'h87654321, 3);
        total_cnt++; if (o_rw !== 4) $display("FAIL wait_read_cycles got %0d want 4", o_rw); else pass_cnt++;
        total_cnt++; if (o_stable !== 1'b1) $display("FAIL wait_stable got %b want 1", o_stable); else pass_cnt++;
        total_cnt++; if (o_lat !== 6) $display("FAIL wait_lat got %0d want 6", o_lat); else pass_cnt++;
        total_cnt++; if (o_rdata !== 64'h87654321 || o_err !== 1'b0) $display("FAIL wait_data got %h/%b want 87654321/0", o_rdata, o_err); else pass_cnt++;
        total_cnt++; if (o_both !== 1'b0) $display("FAIL wait_rw_overlap got %b want 0", o_both); else pass_cnt++;
    endtask

    task automatic test_errors();
        xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h1002, 64'h0, 64'h11111111, 0);
        total_cnt++; if (o_rw !== 0) $display("FAIL lw_mis_bus got %0d want 0", o_rw); else pass_cnt++;
        total_cnt++; if (o_lat !== 1 || o_err !== 1'b1) $display("FAIL lw_mis_resp got %0d/%b want 1/1", o_lat, o_err); else pass_cnt++;
        total_cnt++; if (o_rdata !== 64'h0) $display("FAIL lw_mis_rdata got %h want 0", o_rdata); else pass_cnt++;

        xact(1'b0, 1'b1, 2'd1, 1'b0, 32'h1001, 64'h5555, 64'h0, 0);
        total_cnt++; if (o_rw !== 0 || o_lat !== 1 || o_err !== 1'b1) $display("FAIL sh_mis got %0d/%0d/%b want 0/1/1", o_rw, o_lat, o_err); else pass_cnt++;

        xact(1'b0, 1'b0, 2'd3, 1'b0, 32'h1000, 64'h0, 64'h0, 0);
        total_cnt++; if (o_rw !== 0 || o_lat !== 1 || o_err !== 1'b1) $display("FAIL size3_32 got %0d/%0d/%b want 0/1/1", o_rw, o_lat, o_err); else pass_cnt++;
        total_cnt++; if (o_after_rv !== 1'b0 || o_after_ready !== 1'b1) $display("FAIL size3_pulse got %b/%b want 0/1", o_after_rv, o_after_ready); else pass_cnt++;

        xact(1'b1, 1'b0, 2'd3, 1'b0, 32'h0C, 64'h0, 64'h0, 0);
        total_cnt++; if (o_rw !== 0 || o_lat !== 1 || o_err !== 1'b1) $display("FAIL ld64_mis got %0d/%0d/%b want 0/1/1", o_rw, o_lat, o_err); else pass_cnt++;
    endtask

    task automatic test_timeout();
        xact(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 64'h0, 64'h12345678, 100);
        total_cnt++; if (o_rd !== 1'b1) $display("FAIL to_read got %b want 1", o_rd); else pass_cnt++;
        total_cnt++; if (o_rw !== 4) $display("FAIL to_read_cycles got %0d want 4", o_rw); else pass_cnt++;
        total_cnt++; if (o_lat !== 5 || o_err !== 1'b1) $display("FAIL to_resp got %0d/%b want 5/1", o_lat, o_err); else pass_cnt++;
        total_cnt++; if (o_rdata !== 64'h0) $display("FAIL to_rdata got %h want 0", o_rdata); else pass_cnt++;
        total_cnt++; if (o_after_ready !== 1'b1) $display("FAIL to_ready got %b want 1", o_after_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid_req();
        logic seen_rv;
        sel = 1'b0;
        @(negedge clk);
        req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h2000;
        waitreq = 1'b1; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        total_cnt++; if (a_read !== 1'b1) $display("FAIL mid_read_before got %b want 1", a_read); else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (a_read !== 1'b0 || a_rv !== 1'b0) $display("FAIL mid_reset got %b/%b want 0/0", a_read, a_rv); else pass_cnt++;
        total_cnt++; if (a_addr !== 32'h0) $display("FAIL mid_reset_addr got %h want 0", a_addr); else pass_cnt++;
        reset = 1'b1;
        waitreq = 1'b0;
        @(negedge clk);
        total_cnt++; if (a_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", a_ready); else pass_cnt++;
        seen_rv = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (a_rv) seen_rv = 1'b1;
            @(negedge clk);
        end
        total_cnt++; if (seen_rv !== 1'b0) $display("FAIL mid_no_resp got %b want 0", seen_rv); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; sel = 1'b0; waitreq = 1'b0;
        req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = '0;
        req_wdata = '0; rdata = '0;
        test_reset();
        test_store();
        test_load();
        test_wait();
        test_errors();
        test_timeout();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mips_cpu_lsu.md
Name: mips_cpu_lsu

Overview:
Parametrised load/store unit between the multicycle CPU core and the Avalon memory-mapped bus master port. It takes one byte, half, word or doubleword request at a time and generates the word-aligned address, byteenable and lane-shifted writedata. It handles waitrequest stalls, with an optional timeout, and returns sign- or zero-extended load data with a one-cycle response pulse. Misaligned and illegal-size requests are flagged without touching the bus.

Parameters:
DATA_W, 32, bus data width in bits; legal values 32 or 64; BYTES = DATA_W/8 and OFF_W = log2(BYTES) are derived localparams.
ADDR_W, 32, byte-address width.
MAX_WAIT, 0, maximum consecutive waitrequest cycles before abort; 0 means wait forever.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
req_valid  in  1  core request strobe.
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  access size is 2^req_size bytes (0 byte, 1 half, 2 word, 3 dword).
req_signed  in  1  loads: sign-extend when 1, zero-extend when 0.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-aligned.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
resp_error  out  1  qualifies resp_valid: misaligned, illegal size or timeout.
address  out  ADDR_W  Avalon word address: req_addr with low OFF_W bits zeroed.
read  out  1  Avalon read request.
write  out  1  Avalon write request.
waitrequest  in  1  Avalon stall.
writedata  out  DATA_W  Avalon write data.
byteenable  out  BYTES  Avalon byte lanes.
readdata  in  DATA_W  Avalon read data; valid the cycle after the read is accepted.

Behaviour:
- States: IDLE, REQ, RDATA, DONE.
- Reset (reset==0): state goes to IDLE. read, write, resp_valid, resp_error, resp_rdata, address, writedata and byteenable are all 0. Reset overrides every state, including mid-REQ; no response is issued for the aborted request.
- Request checks on acceptance. off = req_addr[OFF_W-1:0], n = 2^req_size.
  - Illegal when n > BYTES, or when off is not a multiple of n.
  - Illegal request: go IDLE->DONE with resp_error=1. read and write are never asserted. resp_valid is high the cycle after acceptance.
- Legal request, IDLE->REQ:
  - Register address.
  - byteenable = ((1<<n)-1) << off.
  - writedata = (req_wdata low n bytes) << 8*off, other lanes 0.
  - Latch write, size, signed and off.
- Byte lanes are little-endian: byte offset k maps to bits [8k+7:8k].
- REQ: read = !write_l, write = write_l. address, byteenable and writedata are held stable while waitrequest==1.
  - waitrequest==0, store: go to DONE.
  - waitrequest==0, load: go to RDATA.
  - waitrequest==1 and MAX_WAIT!=0: increment the wait counter. When the counter reaches MAX_WAIT and waitrequest is still 1, drop read/write and go to DONE with resp_error=1.
- RDATA: capture readdata >> 8*off and keep the low n bytes.
  - If signed, extend from bit 8n-1; otherwise zero-extend.
  - When n==BYTES, the signed flag is ignored.
  - Then go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then go to IDLE. req_ready is low in DONE.
- Latency from the acceptance cycle T, with no stalls:
  - store response at T+2;
  - load response at T+3;
  - error response at T+1;
  - each waitrequest cycle adds 1.
- read and write are never high together. Both are 0 in IDLE, RDATA and DONE.
- The wait counter clears on every entry to REQ.

Test Plan:
1. DATA_W=32: SW, addr 0x1000, data 0xDEADBEEF, waitrequest=0 -> at T+1 write=1, address=0x1000, byteenable=4'b1111, writedata=0xDEADBEEF; at T+2 resp_valid=1, resp_error=0.
2. SB, addr 0x1003, data 0x000000A5 -> address=0x1000, byteenable=4'b1000, writedata=0xA5000000. SH at 0x1002 with data 0x1234 -> byteenable=4'b1100, writedata=0x12340000.
3. Loads with readdata=0x80011234:
   - LH signed at 0x2002 -> byteenable=4'b1100, resp_rdata=0xFFFF8001.
   - LHU at the same address -> 0x00008001.
   - LB signed at 0x2000 -> 0x00000034.
   - With readdata=0x00008000, LB signed at 0x2001 -> 0xFFFFFF80.
   - Each response arrives at T+3.
4. LW at 0x2000 with waitrequest high for 3 cycles -> read stays high for 4 cycles with address stable, resp_valid at T+6, data correct.
5. LW at 0x1002, SH at 0x1001, and size=3 with DATA_W=32 -> read and write stay 0, resp_valid=1 and resp_error=1 at T+1. With DATA_W=64, an 8-byte load at 0x08 -> byteenable=8'hFF.
6. MAX_WAIT=4, waitrequest stuck at 1 -> read drops after 4 cycles, resp_error=1. Separately, drive reset=0 during REQ -> read=0 after the next edge, no resp_valid, req_ready=1 after reset is released.
